// File: rtl/patp_pkg.sv
// Shared definitions for the tiny program-counter sequencer: widths, opcodes,
// state encoding and the modulo pc increment.
package patp_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 8;
  localparam int OPC_W   = 3;

  localparam logic [OPC_W-1:0] OP_JMP  = 3'b100;
  localparam logic [OPC_W-1:0] OP_JZ   = 3'b101;
  localparam logic [OPC_W-1:0] OP_JNZ  = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } seq_state_t;

  // Wraps 31 -> 0; there is deliberately no carry out.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/pc_seq.sv
// Instruction sequencer: fetches from memory, resolves jumps/HALT itself and
// hands everything else to the datapath; drives the external pc block's we/in.
//
//   state  | meaning
//   IDLE   | halted, waiting for run
//   FETCH  | mem_req held at pc_q until mem_ack latches ir
//   DECODE | jumps/HALT write pc here; other opcodes go to EXEC
//   EXEC   | exe_valid held until exe_ready, then pc <= pc+1
module pc_seq
  import patp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic               pc_we,
  output logic [ADDR_W-1:0]  pc_in,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               exe_valid,
  input  logic               exe_ready,
  input  logic               zero,
  output logic               halted
);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              ir_load;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;

  assign opcode  = ir[INSTR_W-1:INSTR_W-OPC_W];
  assign target  = ir[ADDR_W-1:0];
  assign pc_next = pc_inc(pc_q);
  assign halted  = (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir      <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir <= mem_rdata;
    end
  end

  // Outputs depend on the registered state, so an asynchronous reset kills
  // any pending pc write immediately, even if exe_ready is still high.
  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    pc_in     = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    exe_valid = 1'b0;
    ir_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_JMP: begin
            pc_we   = 1'b1;
            pc_in   = target;
            state_d = ST_FETCH;
          end
          OP_JZ: begin
            pc_we   = 1'b1;
            pc_in   = zero ? target : pc_next;
            state_d = ST_FETCH;
          end
          OP_JNZ: begin
            pc_we   = 1'b1;
            pc_in   = zero ? pc_next : target;
            state_d = ST_FETCH;
          end
          OP_HALT: begin
            pc_we   = 1'b1;
            pc_in   = pc_next;
            state_d = ST_IDLE;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        exe_valid = 1'b1;
        if (exe_ready) begin
          pc_we   = 1'b1;
          pc_in   = pc_next;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
